// File: rtl/pz_game_pkg.sv
// Shared types and timing defaults for the punch-zombie game blocks.
// The half-second constant matches the one used by lfsr_random_v2.
package pz_game_pkg;

    localparam int unsigned HALF_SEC_CYCLES    = 31250000;
    localparam int unsigned GAP_DEFAULT_CYCLES = HALF_SEC_CYCLES / 5;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LATCH,
        WAIT,
        GAP,
        OVER
    } pz_state_t;

    function automatic logic [2:0] tgt_to_onehot(input logic [1:0] tgt);
        logic [2:0] oh;
        case (tgt)
            2'd1:    oh = 3'b001;
            2'd2:    oh = 3'b010;
            2'd3:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/pz_round_ctrl_if.sv
// Request/response link between the round controller and the random-target generator.
interface pz_round_ctrl_if;
    logic       generate_random;
    logic [1:0] rand_num;

    modport master (output generate_random, input rand_num);
    modport slave  (input generate_random, output rand_num);
endinterface

// File: rtl/pz_edge_det.sv
// Width-parameterised rising-edge detector; the previous-value register updates every cycle.
module pz_edge_det #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);
    logic [W-1:0] d_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_prev <= '0;
        else     d_prev <= d;
    end

    assign rise = d & ~d_prev;
endmodule

// File: rtl/pz_round_ctrl.sv
// Round controller: requests a target, times the punch window, judges presses, keeps score.
// Optional macro PZ_SPEEDUP_EN shrinks the punch window by 1/8 every eighth hit.
module pz_round_ctrl
    import pz_game_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = HALF_SEC_CYCLES,
    parameter int unsigned GAP_CYCLES     = GAP_DEFAULT_CYCLES,
    parameter int unsigned SCORE_W        = 8,
    parameter int unsigned MAX_MISS       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         btn,
    pz_round_ctrl_if.master    rif,
    output logic [2:0]         target_led,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         misses,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over,
    output logic               busy
);
    localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [1:0]       MAX_MISS_L = 2'(MAX_MISS);

    pz_state_t          state, state_nxt;
    logic [1:0]         tgt;
    logic [2:0]         tgt_oh;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   win_load;
    logic [2:0]         btn_rise;
    logic               start_rise;
    logic               start_go;
    logic               hit;
    logic               miss;
    logic [SCORE_W-1:0] score_inc;

    pz_edge_det #(.W(3)) u_btn_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (btn),
        .rise (btn_rise)
    );

    pz_edge_det #(.W(1)) u_start_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (start),
        .rise (start_rise)
    );

    assign tgt_oh    = tgt_to_onehot(tgt);
    assign start_go  = start_rise && ((state == IDLE) || (state == OVER));
    // Any non-target bit makes it a miss even if the target bit rose too.
    assign hit       = (state == WAIT) && (btn_rise == tgt_oh);
    assign miss      = (state == WAIT) &&
                       ((|(btn_rise & ~tgt_oh)) || ((btn_rise == 3'b000) && (timer == '0)));
    assign score_inc = (&score) ? score : score + SCORE_W'(1);

`ifdef PZ_SPEEDUP_EN
    localparam logic [TMR_W-1:0] WIN_INIT  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] WIN_FLOOR = TMR_W'(TIMEOUT_CYCLES >> 2);

    logic [TMR_W-1:0] win;
    logic [TMR_W-1:0] win_cut;

    assign win_cut  = win - (win >> 3);
    assign win_load = win - TMR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win <= WIN_INIT;
        end else if (start_go) begin
            win <= WIN_INIT;
        end else if (hit && !(&score) && (score_inc[2:0] == 3'b000)) begin
            win <= (win_cut < WIN_FLOOR) ? WIN_FLOOR : win_cut;
        end
    end
`else
    assign win_load = TMR_W'(TIMEOUT_CYCLES - 1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_rise) state_nxt = REQ;
            REQ:     state_nxt = LATCH;
            LATCH:   state_nxt = (rif.rand_num == 2'd0) ? REQ : WAIT;
            WAIT:    if (hit || miss) state_nxt = GAP;
            GAP:     if (timer == '0) state_nxt = (misses == MAX_MISS_L) ? OVER : REQ;
            OVER:    if (start_rise) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rif.generate_random = 1'b0;
        target_led          = 3'b000;
        game_over           = 1'b0;
        busy                = 1'b1;
        case (state)
            IDLE:    busy = 1'b0;
            REQ:     rif.generate_random = 1'b1;
            WAIT:    target_led = tgt_oh;
            OVER: begin
                game_over  = 1'b1;
                target_led = 3'b111;
                busy       = 1'b0;
            end
            default: ;
        endcase
    end

    // The same timer serves the punch window and the inter-round gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt        <= 2'd0;
            timer      <= '0;
            score      <= '0;
            misses     <= 2'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= hit;
            miss_pulse <= miss;
            if (start_go) begin
                score  <= '0;
                misses <= 2'd0;
            end else begin
                if (hit)  score  <= score_inc;
                if (miss) misses <= misses + 2'd1;
            end
            case (state)
                LATCH: begin
                    if (rif.rand_num != 2'd0) begin
                        tgt   <= rif.rand_num;
                        timer <= win_load;
                    end
                end
                WAIT:    timer <= (hit || miss) ? GAP_LOAD : timer - TMR_W'(1);
                GAP:     if (timer != '0) timer <= timer - TMR_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pz_round_ctrl.sv
// Directed bench for pz_round_ctrl with a small queue-driven random-target generator model.
module tb_pz_round_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] btn;
    logic [2:0] target_led;
    logic [7:0] score;
    logic [1:0] misses;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       game_over;
    logic       busy;

    int vectors    = 0;
    int miscompares = 0;

    logic [1:0] rn_q[$];

`ifdef PZ_SPEEDUP_EN
    localparam int EXP_WIN = 18;
`else
    localparam int EXP_WIN = 20;
`endif

    pz_round_ctrl_if rif();

    pz_round_ctrl #(
        .TIMEOUT_CYCLES (20),
        .GAP_CYCLES     (4),
        .SCORE_W        (8),
        .MAX_MISS       (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .btn        (btn),
        .rif        (rif),
        .target_led (target_led),
        .score      (score),
        .misses     (misses),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .game_over  (game_over),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Generator model: registers the next queued value on the request cycle, 1 when empty.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rif.rand_num <= 2'd0;
        end else if (rif.generate_random) begin
            if (rn_q.size() > 0) rif.rand_num <= rn_q.pop_front();
            else                 rif.rand_num <= 2'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; btn = 3'b000;
        repeat (3) tick();
        vectors++;
        if ({rif.generate_random, target_led, score, misses, hit_pulse, miss_pulse, game_over, busy} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got gen=%b led=%b score=%0d misses=%0d hit=%b miss=%b over=%b busy=%b, want all 0",
                     rif.generate_random, target_led, score, misses, hit_pulse, miss_pulse, game_over, busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_hit();
        rn_q.push_back(2'd2);
        start = 1'b1;
        tick();
        vectors++;
        if (rif.generate_random !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL hit_req_strobe: got gen=%b busy=%b, want 1 1", rif.generate_random, busy);
        end
        tick();
        vectors++;
        if (rif.generate_random !== 1'b0 || target_led !== 3'b000) begin
            miscompares++;
            $display("FAIL hit_latch_cycle: got gen=%b led=%b, want 0 000", rif.generate_random, target_led);
        end
        tick();
        vectors++;
        if (target_led !== 3'b010) begin
            miscompares++;
            $display("FAIL hit_target_led: got %b want 010", target_led);
        end
        btn = 3'b010;
        tick();
        vectors++;
        if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 8'd1 || target_led !== 3'b000) begin
            miscompares++;
            $display("FAIL hit_judged: got hit=%b miss=%b score=%0d led=%b, want 1 0 1 000",
                     hit_pulse, miss_pulse, score, target_led);
        end
        btn = 3'b000;
        tick();
        vectors++;
        if (hit_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL hit_pulse_width: got %b want 0", hit_pulse);
        end
        repeat (2) tick();
        vectors++;
        if (target_led !== 3'b000 || rif.generate_random !== 1'b0) begin
            miscompares++;
            $display("FAIL hit_gap_blank: got led=%b gen=%b, want 000 0", target_led, rif.generate_random);
        end
        tick();
        vectors++;
        if (rif.generate_random !== 1'b1) begin
            miscompares++;
            $display("FAIL hit_next_req: got gen=%b want 1", rif.generate_random);
        end
    endtask

    task automatic test_wrong_button();
        rn_q.push_back(2'd3);
        repeat (2) tick();
        vectors++;
        if (target_led !== 3'b100) begin
            miscompares++;
            $display("FAIL wrong_target_led: got %b want 100", target_led);
        end
        btn = 3'b011;
        tick();
        vectors++;
        if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || misses !== 2'd1 || score !== 8'd1) begin
            miscompares++;
            $display("FAIL wrong_judged: got miss=%b hit=%b misses=%0d score=%0d, want 1 0 1 1",
                     miss_pulse, hit_pulse, misses, score);
        end
        btn = 3'b000;
        repeat (4) tick();
    endtask

    task automatic test_timeout_over();
        for (int r = 0; r < 2; r++) begin
            rn_q.push_back(2'd1);
            repeat (2) tick();
            repeat (19) tick();
            vectors++;
            if (miss_pulse !== 1'b0 || target_led !== 3'b001) begin
                miscompares++;
                $display("FAIL timeout_early_r%0d: got miss=%b led=%b, want 0 001", r, miss_pulse, target_led);
            end
            tick();
            vectors++;
            if (miss_pulse !== 1'b1 || misses !== 2'(r + 2)) begin
                miscompares++;
                $display("FAIL timeout_miss_r%0d: got miss=%b misses=%0d, want 1 %0d", r, miss_pulse, misses, r + 2);
            end
            repeat (4) tick();
        end
        vectors++;
        if (game_over !== 1'b1 || target_led !== 3'b111 || busy !== 1'b0 || misses !== 2'd3 || score !== 8'd1) begin
            miscompares++;
            $display("FAIL over_state: got over=%b led=%b busy=%b misses=%0d score=%0d, want 1 111 0 3 1",
                     game_over, target_led, busy, misses, score);
        end
        tick();
        vectors++;
        if (game_over !== 1'b1 || rif.generate_random !== 1'b0) begin
            miscompares++;
            $display("FAIL over_hold: got over=%b gen=%b, want 1 0", game_over, rif.generate_random);
        end
    endtask

    task automatic test_rand_zero();
        start = 1'b0;
        tick();
        rn_q.push_back(2'd0);
        rn_q.push_back(2'd2);
        start = 1'b1;
        tick();
        vectors++;
        if (rif.generate_random !== 1'b1 || score !== 8'd0 || misses !== 2'd0 || game_over !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_clear: got gen=%b score=%0d misses=%0d over=%b busy=%b, want 1 0 0 0 1",
                     rif.generate_random, score, misses, game_over, busy);
        end
        tick();
        vectors++;
        if (target_led !== 3'b000 || rif.generate_random !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_latch: got led=%b gen=%b, want 000 0", target_led, rif.generate_random);
        end
        tick();
        vectors++;
        if (rif.generate_random !== 1'b1 || target_led !== 3'b000) begin
            miscompares++;
            $display("FAIL zero_rereq: got gen=%b led=%b, want 1 000", rif.generate_random, target_led);
        end
        repeat (2) tick();
        vectors++;
        if (target_led !== 3'b010) begin
            miscompares++;
            $display("FAIL zero_valid_led: got %b want 010", target_led);
        end
        btn = 3'b010;
        tick();
        btn = 3'b000;
    endtask

    task automatic test_held_button();
        repeat (3) tick();
        rn_q.push_back(2'd3);
        tick();
        btn = 3'b100;
        repeat (2) tick();
        repeat (3) tick();
        vectors++;
        if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || target_led !== 3'b100) begin
            miscompares++;
            $display("FAIL held_no_judge: got hit=%b miss=%b led=%b, want 0 0 100", hit_pulse, miss_pulse, target_led);
        end
        btn = 3'b000;
        tick();
        btn = 3'b100;
        tick();
        vectors++;
        if (hit_pulse !== 1'b1 || score !== 8'd2) begin
            miscompares++;
            $display("FAIL held_repress_hit: got hit=%b score=%0d, want 1 2", hit_pulse, score);
        end
        btn = 3'b000;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 253; i++) begin
            repeat (6) tick();
            btn = 3'b001;
            tick();
            btn = 3'b000;
        end
        vectors++;
        if (score !== 8'd255) begin
            miscompares++;
            $display("FAIL sat_reach: got score=%0d want 255", score);
        end
        repeat (6) tick();
        btn = 3'b001;
        tick();
        btn = 3'b000;
        vectors++;
        if (score !== 8'd255 || hit_pulse !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_hold: got score=%0d hit=%b, want 255 1", score, hit_pulse);
        end
    endtask

    task automatic test_reset_mid();
        repeat (6) tick();
        vectors++;
        if (target_led !== 3'b001 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_pre: got led=%b busy=%b, want 001 1", target_led, busy);
        end
        #2;
        rst = 1'b1;
        start = 1'b0;
        #1;
        vectors++;
        if ({rif.generate_random, target_led, score, misses, hit_pulse, miss_pulse, game_over, busy} !== 18'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got gen=%b led=%b score=%0d misses=%0d hit=%b miss=%b over=%b busy=%b, want all 0",
                     rif.generate_random, target_led, score, misses, hit_pulse, miss_pulse, game_over, busy);
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || rif.generate_random !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_idle: got busy=%b gen=%b, want 0 0", busy, rif.generate_random);
        end
    endtask

    task automatic test_window_after_8_hits();
        start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            repeat (2) tick();
            btn = 3'b001;
            tick();
            btn = 3'b000;
            repeat (4) tick();
        end
        vectors++;
        if (score !== 8'd8) begin
            miscompares++;
            $display("FAIL win_score8: got score=%0d want 8", score);
        end
        repeat (2) tick();
        repeat (EXP_WIN - 1) tick();
        vectors++;
        if (miss_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL win_early: got miss=%b want 0 after %0d cycles", miss_pulse, EXP_WIN - 1);
        end
        tick();
        vectors++;
        if (miss_pulse !== 1'b1) begin
            miscompares++;
            $display("FAIL win_length: got miss=%b want 1 after %0d cycles", miss_pulse, EXP_WIN);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hit();
        test_wrong_button();
        test_timeout_over();
        test_rand_zero();
        test_held_button();
        test_saturation();
        test_reset_mid();
        test_window_after_8_hits();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
